vga_config_sequencer: RTL and testbench

- Sits directly upstream of the VGA controller and owns its configuration bus (c_valid/c_addr/c_data/c_ready).
- Merges two sources of configuration writes into a small command FIFO: a debounced 2-bit resolution switch and a generic request port (e.g. UART/CPU).
- Replays queued writes to the VGA controller one at a time, honouring c_ready.
- Resolution codes: 00 = 640x480, 01 = 800x600, 10 = 1024x768.

---
 rtl/vga_config_sequencer_pkg.sv | 25 ++
 rtl/vga_config_sequencer_cfg_fifo.sv | 54 +++++
 rtl/vga_config_sequencer.sv | 157 +++++++++++++++
 tb/tb_vga_config_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_config_sequencer_pkg.sv
// Shared definitions for the VGA configuration sequencer: config bus widths,
// resolution codes and the replay FSM state encoding.
package vga_config_sequencer_pkg;

  localparam int CONFIG_WIDTH = 4;
  localparam int VGA_RES_ADDR = 2;

  typedef enum logic [1:0] {
    RES_640     = 2'b00,
    RES_800     = 2'b01,
    RES_1024    = 2'b10,
    RES_INVALID = 2'b11
  } res_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_e;

  function automatic logic res_is_valid(input logic [1:0] code);
    return code != RES_INVALID;
  endfunction

endpackage

// File: rtl/vga_config_sequencer_cfg_fifo.sv
// Small synchronous command FIFO; head entry is presented combinationally so
// the replay FSM can latch it on the same edge that pops it.
module cfg_fifo
  import vga_config_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vga_config_sequencer.sv
// Owns the VGA controller config bus: merges debounced resolution-switch writes
// and external requests into a FIFO and replays them one handshake at a time.
module vga_config_sequencer
  import vga_config_sequencer_pkg::*;
#(
  parameter int CONFIG_WIDTH    = vga_config_sequencer_pkg::CONFIG_WIDTH,
  parameter int FIFO_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int VGA_RES_ADDR    = vga_config_sequencer_pkg::VGA_RES_ADDR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              res_sel,
  input  logic                    req_valid,
  input  logic [CONFIG_WIDTH-1:0] req_addr,
  input  logic [CONFIG_WIDTH-1:0] req_data,
  output logic                    req_ready,
  output logic                    c_valid,
  output logic [CONFIG_WIDTH-1:0] c_addr,
  output logic [CONFIG_WIDTH-1:0] c_data,
  input  logic                    c_ready,
  output logic                    busy,
  output logic                    err_invalid
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int EW = 2 * CONFIG_WIDTH;
  localparam int FAW = $clog2(FIFO_DEPTH);

  logic [1:0]       sync1_q, sync2_q, prev_q, accepted_q, sw_code_q, sw_code_d;
  logic [CNT_W-1:0] db_cnt_q;
  logic             sw_pending_q, sw_pending_d;
  logic             err_q;
  logic             accept;

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EW-1:0]    fifo_wdata, fifo_rdata;
  logic [FAW:0]     fifo_count;
  logic             sw_push, req_push;

  state_e                  state_q;
  logic                    c_valid_q;
  logic [CONFIG_WIDTH-1:0] c_addr_q, c_data_q;
  logic                    seen_low_q, high_seen_q;

  // A value is accepted once it has been stable for DEBOUNCE_CYCLES samples
  // and differs from the last accepted value (including an accepted 11).
  assign accept = (sync2_q == prev_q) && (db_cnt_q == DB_MAX) && (sync2_q != accepted_q);

  always_comb begin
    sw_pending_d = sw_pending_q;
    sw_code_d    = sw_code_q;
    if (accept && res_is_valid(sync2_q)) begin
      sw_pending_d = 1'b1;
      sw_code_d    = sync2_q;
    end else if (sw_push) begin
      sw_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      db_cnt_q     <= '0;
      accepted_q   <= RES_640;
      sw_pending_q <= 1'b0;
      sw_code_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= res_sel;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      sw_pending_q <= sw_pending_d;
      sw_code_q    <= sw_code_d;
      if (sync2_q != prev_q)    db_cnt_q <= '0;
      else if (db_cnt_q != DB_MAX) db_cnt_q <= db_cnt_q + 1'b1;
      if (accept) accepted_q <= sync2_q;
      if (accept && !res_is_valid(sync2_q)) err_q <= 1'b1;
    end
  end

  // The switch entry always wins the single enqueue slot.
  assign sw_push    = sw_pending_q && !fifo_full;
  assign req_ready  = rst_n && !fifo_full && !sw_pending_q;
  assign req_push   = req_valid && req_ready;
  assign fifo_push  = sw_push || req_push;
  assign fifo_wdata = sw_push ? {CONFIG_WIDTH'(VGA_RES_ADDR), CONFIG_WIDTH'(sw_code_q)}
                              : {req_addr, req_data};
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;

  cfg_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // WAIT releases after c_ready goes low-then-high, or stays high for two
  // cycles, so both a real Load_config pulse and a zero-length one are covered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      c_valid_q   <= 1'b0;
      c_addr_q    <= '0;
      c_data_q    <= '0;
      seen_low_q  <= 1'b0;
      high_seen_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            {c_addr_q, c_data_q} <= fifo_rdata;
            c_valid_q            <= 1'b1;
            state_q              <= ISSUE;
          end
        end
        ISSUE: begin
          if (c_valid_q && c_ready) begin
            c_valid_q   <= 1'b0;
            seen_low_q  <= 1'b0;
            high_seen_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (!c_ready) begin
            seen_low_q  <= 1'b1;
            high_seen_q <= 1'b0;
          end else if (seen_low_q || high_seen_q) begin
            state_q <= IDLE;
          end else begin
            high_seen_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_valid     = c_valid_q;
  assign c_addr      = c_addr_q;
  assign c_data      = c_data_q;
  assign err_invalid = err_q;
  assign busy        = (fifo_count != '0) || (state_q != IDLE) || sw_pending_q;

endmodule

// File: tb/tb_vga_config_sequencer.sv
// Directed bench for vga_config_sequencer: switch debounce, request queueing,
// switch priority, invalid code handling and mid-transfer reset.
module tb_vga_config_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] res_sel = 2'b00;
  logic       req_valid = 1'b0;
  logic [3:0] req_addr = 4'd0;
  logic [3:0] req_data = 4'd0;
  logic       req_ready;
  logic       c_valid;
  logic [3:0] c_addr;
  logic [3:0] c_data;
  logic       c_ready = 1'b1;
  logic       busy;
  logic       err_invalid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] hs_addr [$];
  logic [3:0] hs_data [$];
  int         hs_cyc  [$];

  logic [3:0] exp_a [6] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2};
  logic [3:0] exp_d [6] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};

  vga_config_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_sel     (res_sel),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .c_valid     (c_valid),
    .c_addr      (c_addr),
    .c_data      (c_data),
    .c_ready     (c_ready),
    .busy        (busy),
    .err_invalid (err_invalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && c_valid && c_ready) begin
      hs_addr.push_back(c_addr);
      hs_data.push_back(c_data);
      hs_cyc.push_back(cyc);
      $display("handshake cycle=%0d addr=%0d data=%0d", cyc, c_addr, c_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hs(input int n, input int budget);
    int b;
    b = budget;
    while (hs_data.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("hs_count_reached", hs_data.size(), n);
  endtask

  function automatic logic [3:0] hsa(input int i);
    return (i < hs_addr.size()) ? hs_addr[i] : 4'bxxxx;
  endfunction

  function automatic logic [3:0] hsd(input int i);
    return (i < hs_data.size()) ? hs_data[i] : 4'bxxxx;
  endfunction

  function automatic int hsc(input int i);
    return (i < hs_cyc.size()) ? hs_cyc[i] : 0;
  endfunction

  initial begin
    // Reset state
    cycles(3);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_addr", c_addr, 0);
    chk("rst_c_data", c_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_invalid, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Single switch write
    res_sel = 2'b01;
    wait_hs(1, 40);
    chk("sw1_addr", hsa(0), 2);
    chk("sw1_data", hsd(0), 1);
    cycles(10);
    chk("sw1_only_one", hs_data.size(), 1);
    chk("sw1_busy_idle", busy, 0);
    chk("sw1_err", err_invalid, 0);

    // Bouncing switch, then settle on 10
    for (int k = 0; k < 20; k++) begin
      res_sel = k[0] ? 2'b01 : 2'b00;
      cycles(5);
    end
    chk("bounce_no_write", hs_data.size(), 1);
    res_sel = 2'b10;
    cycles(17);
    chk("settle_not_early", hs_data.size(), 1);
    wait_hs(2, 20);
    chk("settle_addr", hsa(1), 2);
    chk("settle_data", hsd(1), 2);
    cycles(8);
    chk("settle_busy_idle", busy, 0);

    // Fill FIFO with c_ready low
    c_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("fill_req_ready", req_ready, 1);
      req_valid = 1'b1;
      req_addr  = 4'd3;
      req_data  = 4'(5 + k);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("full_req_ready", req_ready, 0);
    chk("full_c_valid", c_valid, 1);
    chk("full_c_addr", c_addr, 3);
    chk("full_c_data", c_data, 5);
    chk("full_busy", busy, 1);

    // Switch write pending while full; free one slot with a c_ready pulse
    res_sel = 2'b01;
    cycles(25);
    chk("pend_req_ready", req_ready, 0);
    chk("pend_c_data_hold", c_data, 5);
    chk("pend_no_hs", hs_data.size(), 2);
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    @(negedge clk);
    c_ready = 1'b1;
    @(negedge clk);
    chk("pulse_req_ready_full", req_ready, 0);
    @(negedge clk);
    chk("pulse_req_ready_sw_slot", req_ready, 0);
    wait_hs(8, 80);
    for (int i = 0; i < 6; i++) begin
      chk("order_addr", hsa(2 + i), exp_a[i]);
      chk("order_data", hsd(2 + i), exp_d[i]);
    end
    for (int i = 4; i < 8; i++) begin
      chk("hs_spacing_ge3", (hsc(i) - hsc(i - 1)) >= 3, 1);
    end

    // Invalid code, then a valid one
    res_sel = 2'b11;
    cycles(25);
    chk("inv_err_set", err_invalid, 1);
    chk("inv_no_write", hs_data.size(), 8);
    res_sel = 2'b00;
    wait_hs(9, 40);
    chk("after_inv_addr", hsa(8), 2);
    chk("after_inv_data", hsd(8), 0);
    chk("inv_err_sticky", err_invalid, 1);
    cycles(8);

    // Reset during ISSUE
    c_ready   = 1'b0;
    req_valid = 1'b1;
    req_addr  = 4'd3;
    req_data  = 4'd4;
    @(negedge clk);
    req_valid = 1'b0;
    cycles(2);
    chk("issue_c_valid", c_valid, 1);
    chk("issue_c_data", c_data, 4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_c_valid", c_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_err_clear", err_invalid, 0);
    rst_n   = 1'b1;
    c_ready = 1'b1;
    cycles(25);
    chk("midrst_no_hs", hs_data.size(), 9);
    chk("midrst_c_valid_low", c_valid, 0);
    chk("midrst_busy_low", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
